// File: rtl/incdev_commit_queue_if.sv
// Handshake bundle between the reference commit stream, the queue and the user CPU.
// master drives the reference records and user finishes; slave is the queue.
interface incdev_commit_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          ref_ex_finish;
    logic          ref_impl;
    logic [31:0]   ref_wb_pc;
    logic [31:0]   ref_wb_inst;
    logic          ref_wb_we;
    logic [4:0]    ref_wb_rfnum;
    logic [31:0]   ref_wb_wdata;
    logic          ref_pc_wr;
    logic [31:0]   ref_pc_target;
    logic          ref_pause;
    logic          usr_ex_flag;
    logic [31:0]   usr_ex_inst;
    logic [31:0]   usr_ex_pc;
    logic          usr_ex_finish;
    logic          usr_wb_we;
    logic [31:0]   usr_wb_pc;
    logic [4:0]    usr_wb_wreg;
    logic [31:0]   usr_wb_wdata;
    logic          usr_pc_inc;
    logic          usr_pc_we;
    logic [31:0]   usr_pc;
    logic [CW-1:0] q_count;
    logic [7:0]    outst;
    logic          ovf_err;
    logic          proto_err;

    modport master (
        output ref_ex_finish, ref_impl, ref_wb_pc, ref_wb_inst,
        output ref_wb_we, ref_wb_rfnum, ref_wb_wdata,
        output ref_pc_wr, ref_pc_target, usr_ex_finish,
        input  ref_pause, usr_ex_flag, usr_ex_inst, usr_ex_pc,
        input  usr_wb_we, usr_wb_pc, usr_wb_wreg, usr_wb_wdata,
        input  usr_pc_inc, usr_pc_we, usr_pc,
        input  q_count, outst, ovf_err, proto_err
    );

    modport slave (
        input  ref_ex_finish, ref_impl, ref_wb_pc, ref_wb_inst,
        input  ref_wb_we, ref_wb_rfnum, ref_wb_wdata,
        input  ref_pc_wr, ref_pc_target, usr_ex_finish,
        output ref_pause, usr_ex_flag, usr_ex_inst, usr_ex_pc,
        output usr_wb_we, usr_wb_pc, usr_wb_wreg, usr_wb_wdata,
        output usr_pc_inc, usr_pc_we, usr_pc,
        output q_count, outst, ovf_err, proto_err
    );
endinterface

// File: rtl/incdev_commit_queue.sv
// In-order commit queue: dispatches implemented instructions to the user CPU and
// applies unimplemented updates / redirects once older work has drained.
module incdev_commit_queue #(
    parameter int DEPTH       = 8,
    parameter int PIPE_MODE   = 0,
    parameter int MAX_OUTST   = 4,
    parameter int AFULL_SLACK = 2
) (
    input logic                 clk,
    input logic                 rstn,
    incdev_commit_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] MAX_EFF = (PIPE_MODE != 0) ? 8'(MAX_OUTST) : 8'd1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] PAUSE_CNT = CW'(DEPTH - AFULL_SLACK);

    typedef struct packed {
        logic        impl;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rfnum;
        logic [31:0] wdata;
        logic        pc_wr;
        logic [31:0] target;
    } rec_t;

    typedef struct packed {
        logic [AW-1:0] head;
        logic [AW-1:0] tail;
        logic [CW-1:0] count;
        logic [7:0]    outst;
        logic          redir_pend;
        logic [31:0]   redir_tgt;
        logic          ovf;
        logic          proto;
        logic          ex_flag;
        logic [31:0]   ex_inst;
        logic [31:0]   ex_pc;
        logic          wb_we;
        logic [31:0]   wb_pc;
        logic [4:0]    wb_wreg;
        logic [31:0]   wb_wdata;
        logic          pc_inc;
        logic          pc_we;
        logic [31:0]   pc;
    } st_t;

    rec_t mem_q [DEPTH];
    st_t  st_q, st_d;
    rec_t wr_rec, hd;
    logic push_ok, fin_ok, pop, issue;
    logic [7:0] eff_out;

    always_comb begin
        wr_rec = '{impl: bus.ref_impl, inst: bus.ref_wb_inst,
                   pc: bus.ref_wb_pc, we: bus.ref_wb_we,
                   rfnum: bus.ref_wb_rfnum, wdata: bus.ref_wb_wdata,
                   pc_wr: bus.ref_pc_wr, target: bus.ref_pc_target};
        hd      = mem_q[st_q.head];
        push_ok = bus.ref_ex_finish && (st_q.count != FULL_CNT);
        fin_ok  = bus.usr_ex_finish && (st_q.outst != 8'd0);
        eff_out = st_q.outst - {7'd0, fin_ok};
        pop     = 1'b0;
        issue   = 1'b0;

        st_d         = st_q;
        st_d.ex_flag = 1'b0;
        st_d.wb_we   = 1'b0;
        st_d.pc_inc  = 1'b0;
        st_d.pc_we   = 1'b0;
        st_d.ovf     = st_q.ovf | (bus.ref_ex_finish && !push_ok);
        st_d.proto   = st_q.proto | (bus.usr_ex_finish && !fin_ok);

        // A pending redirect blocks the head until every older issue finishes.
        if (st_q.redir_pend) begin
            if (eff_out == 8'd0) begin
                st_d.pc_we      = 1'b1;
                st_d.pc         = st_q.redir_tgt;
                st_d.redir_pend = 1'b0;
            end
        end else if (st_q.count != '0) begin
            if (hd.impl) begin
                if (eff_out < MAX_EFF && st_q.outst != 8'hff) begin
                    pop          = 1'b1;
                    issue        = 1'b1;
                    st_d.ex_flag = 1'b1;
                    st_d.ex_inst = hd.inst;
                    st_d.ex_pc   = hd.pc;
                    if (hd.pc_wr) begin
                        st_d.redir_pend = 1'b1;
                        st_d.redir_tgt  = hd.target;
                    end
                end
            end else if (eff_out == 8'd0) begin
                pop           = 1'b1;
                st_d.wb_we    = hd.we;
                st_d.wb_pc    = hd.pc;
                st_d.wb_wreg  = hd.rfnum;
                st_d.wb_wdata = hd.wdata;
                if (hd.pc_wr) begin
                    st_d.pc_we = 1'b1;
                    st_d.pc    = hd.target;
                end else begin
                    st_d.pc_inc = 1'b1;
                end
            end
        end

        st_d.head  = st_q.head + AW'(pop);
        st_d.tail  = st_q.tail + AW'(push_ok);
        st_d.count = st_q.count + CW'(push_ok) - CW'(pop);
        st_d.outst = st_q.outst + {7'd0, issue} - {7'd0, fin_ok};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st_q <= '0;
        else       st_q <= st_d;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[st_q.tail] <= wr_rec;
    end

    assign bus.ref_pause    = (st_q.count >= PAUSE_CNT);
    assign bus.usr_ex_flag  = st_q.ex_flag;
    assign bus.usr_ex_inst  = st_q.ex_inst;
    assign bus.usr_ex_pc    = st_q.ex_pc;
    assign bus.usr_wb_we    = st_q.wb_we;
    assign bus.usr_wb_pc    = st_q.wb_pc;
    assign bus.usr_wb_wreg  = st_q.wb_wreg;
    assign bus.usr_wb_wdata = st_q.wb_wdata;
    assign bus.usr_pc_inc   = st_q.pc_inc;
    assign bus.usr_pc_we    = st_q.pc_we;
    assign bus.usr_pc       = st_q.pc;
    assign bus.q_count      = st_q.count;
    assign bus.outst        = st_q.outst;
    assign bus.ovf_err      = st_q.ovf;
    assign bus.proto_err    = st_q.proto;
endmodule
